// File: rtl/bus_initiator_if.sv
// ---------------------------------------------------------------------------
// bus_initiator_if
// Groups the host command/response handshakes and the single-cycle peripheral
// bus of the bus initiator into one bundle.
//
// Signals:
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata  host -> initiator command
//   rsp_valid/rsp_ready/rsp_rdata                  initiator -> host read data
//   busy                                           initiator activity flag
//   bus_a/bus_we/bus_wd                            initiator -> slave bus
//   bus_rd                                         slave -> initiator read data
//
// Modports:
//   master : the initiator's view (drives the bus, answers the host)
//   slave  : the environment's view (host engine plus bus slaves)
// ---------------------------------------------------------------------------
interface bus_initiator_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_ready;

    logic          busy;

    logic [AW-1:0] bus_a;
    logic          bus_we;
    logic [DW-1:0] bus_wd;
    logic [DW-1:0] bus_rd;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_rd,
        output cmd_ready, rsp_valid, rsp_rdata, busy, bus_a, bus_we, bus_wd
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_rd,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, bus_a, bus_we, bus_wd
    );
endinterface

// File: rtl/bus_initiator.sv
// ---------------------------------------------------------------------------
// bus_initiator
// Requesting end of the single-cycle peripheral bus. Host commands
// {we, addr, wdata} are queued in a small FIFO, each one is issued as a single
// bus access in acceptance order, and read data is returned over a
// valid/ready response handshake. A read response always completes before any
// later command is issued.
//
// Parameters:
//   AW          bus address width
//   DW          bus data width
//   FIFO_DEPTH  command FIFO entries (power of two, >= 2)
//   RD_WAIT     extra address-hold cycles before read sampling
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   busIf  bus_initiator_if.master: command/response handshakes and bus
//
// Build option:
//   BUS_INIT_RDWAIT_EN  when defined, reads pass through a WAIT state that
//                       holds bus_a for RD_WAIT further cycles before bus_rd
//                       is sampled (for slaves with registered read data).
//                       When undefined, WAIT and its counter do not exist,
//                       RD_WAIT has no effect and reads sample at the end of
//                       ACCESS.
// ---------------------------------------------------------------------------
module bus_initiator #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_WAIT    = 1
) (
    input  logic            clk,
    input  logic            rst,
    bus_initiator_if.master busIf
);

    localparam int PtrW = $clog2(FIFO_DEPTH);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    // Reject configurations the FIFO pointer arithmetic cannot handle.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gDepthCheck
        $error("bus_initiator: FIFO_DEPTH must be a power of two >= 2");
    end
    if (RD_WAIT < 0) begin : gRdWaitCheck
        $error("bus_initiator: RD_WAIT must not be negative");
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmdEntryT;

`ifdef BUS_INIT_RDWAIT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } stateT;

    // Counts the remaining WAIT cycles; largest value held is RD_WAIT-1.
    localparam int WaitW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    logic [WaitW-1:0] waitCntR;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd3
    } stateT;
`endif

    // Command FIFO
    cmdEntryT          fifoMem [FIFO_DEPTH];
    logic [PtrW-1:0]   wrPtrR;
    logic [PtrW-1:0]   rdPtrR;
    logic [CntW-1:0]   countR;
    logic [CntW-1:0]   countNextS;
    logic              notEmptyS;
    logic              pushS;
    logic              popS;
    cmdEntryT          headS;

    // FSM and registered outputs
    stateT             stateR;
    logic              idleNextS;
    logic [AW-1:0]     busAR;
    logic              busWeR;
    logic [DW-1:0]     busWdR;
    logic              rspValidR;
    logic [DW-1:0]     rspRdataR;
    logic              cmdReadyR;
    logic              busyR;

    assign headS     = fifoMem[rdPtrR];
    assign notEmptyS = (countR != {CntW{1'b0}});
    // cmdReadyR is exactly !full, so a full FIFO never accepts, even when a
    // pop happens on the same edge.
    assign pushS     = busIf.cmd_valid && cmdReadyR;

    // Pop decision: a new command is taken from IDLE, straight after a write
    // access, or on the edge that hands a read response to the host.
    always_comb begin
        popS = 1'b0;
        case (stateR)
            IDLE:    popS = notEmptyS;
            ACCESS:  popS = busWeR && notEmptyS;
            RESP:    popS = busIf.rsp_ready && notEmptyS;
            default: popS = 1'b0;
        endcase
    end

    // Next FIFO occupancy; a simultaneous push and pop leave it unchanged.
    always_comb begin
        countNextS = countR + CntW'(pushS) - CntW'(popS);
    end

    // Whether the FSM lands in IDLE on the coming edge; feeds the registered
    // busy flag so it tracks the state and count it summarises.
    always_comb begin
        idleNextS = 1'b0;
        case (stateR)
            IDLE:    idleNextS = !popS;
            ACCESS:  idleNextS = busWeR && !popS;
            RESP:    idleNextS = busIf.rsp_ready && !popS;
            default: idleNextS = 1'b0;
        endcase
    end

    // FIFO payload storage; entries are only observed while counted as
    // valid, so the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (pushS) begin
            fifoMem[wrPtrR] <= '{we: busIf.cmd_we, addr: busIf.cmd_addr, wdata: busIf.cmd_wdata};
        end
    end

    // FIFO pointers, occupancy and the host-facing ready/busy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrR    <= {PtrW{1'b0}};
            rdPtrR    <= {PtrW{1'b0}};
            countR    <= {CntW{1'b0}};
            cmdReadyR <= 1'b1;
            busyR     <= 1'b0;
        end else begin
            if (pushS) begin
                wrPtrR <= wrPtrR + PtrW'(1'b1);
            end
            if (popS) begin
                rdPtrR <= rdPtrR + PtrW'(1'b1);
            end
            countR    <= countNextS;
            cmdReadyR <= (countNextS != FullCount);
            busyR     <= (countNextS != {CntW{1'b0}}) || !idleNextS;
        end
    end

    // Access sequencer: issues one bus access per command and owns every
    // bus-side and response-side output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR    <= IDLE;
            busAR     <= {AW{1'b0}};
            busWeR    <= 1'b0;
            busWdR    <= {DW{1'b0}};
            rspValidR <= 1'b0;
            rspRdataR <= {DW{1'b0}};
`ifdef BUS_INIT_RDWAIT_EN
            waitCntR  <= {WaitW{1'b0}};
`endif
        end else begin
            case (stateR)
                IDLE: begin
                    if (popS) begin
                        busAR  <= headS.addr;
                        busWdR <= headS.wdata;
                        busWeR <= headS.we;
                        stateR <= ACCESS;
                    end else begin
                        busWeR <= 1'b0;
                        stateR <= IDLE;
                    end
                end

                ACCESS: begin
                    if (busWeR) begin
                        // The slave commits the write on this edge; chain
                        // straight into the next command when one is queued.
                        if (popS) begin
                            busAR  <= headS.addr;
                            busWdR <= headS.wdata;
                            busWeR <= headS.we;
                            stateR <= ACCESS;
                        end else begin
                            busWeR <= 1'b0;
                            stateR <= IDLE;
                        end
                    end else begin
`ifdef BUS_INIT_RDWAIT_EN
                        if (RD_WAIT > 0) begin
                            waitCntR <= WaitW'(RD_WAIT - 1);
                            stateR   <= WAIT;
                        end else begin
                            rspRdataR <= busIf.bus_rd;
                            rspValidR <= 1'b1;
                            stateR    <= RESP;
                        end
`else
                        rspRdataR <= busIf.bus_rd;
                        rspValidR <= 1'b1;
                        stateR    <= RESP;
`endif
                    end
                end

`ifdef BUS_INIT_RDWAIT_EN
                WAIT: begin
                    // bus_a is simply left alone here, holding the address.
                    if (waitCntR == {WaitW{1'b0}}) begin
                        rspRdataR <= busIf.bus_rd;
                        rspValidR <= 1'b1;
                        stateR    <= RESP;
                    end else begin
                        waitCntR <= waitCntR - WaitW'(1'b1);
                        stateR   <= WAIT;
                    end
                end
`endif

                RESP: begin
                    // Nothing further is issued until the host takes the
                    // response, which keeps later writes behind the read.
                    if (busIf.rsp_ready) begin
                        rspValidR <= 1'b0;
                        if (popS) begin
                            busAR  <= headS.addr;
                            busWdR <= headS.wdata;
                            busWeR <= headS.we;
                            stateR <= ACCESS;
                        end else begin
                            stateR <= IDLE;
                        end
                    end else begin
                        stateR <= RESP;
                    end
                end

                default: begin
                    busWeR    <= 1'b0;
                    rspValidR <= 1'b0;
                    stateR    <= IDLE;
                end
            endcase
        end
    end

    assign busIf.cmd_ready = cmdReadyR;
    assign busIf.busy      = busyR;
    assign busIf.bus_a     = busAR;
    assign busIf.bus_we    = busWeR;
    assign busIf.bus_wd    = busWdR;
    assign busIf.rsp_valid = rspValidR;
    assign busIf.rsp_rdata = rspRdataR;

endmodule

// File: tb/tb_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_bus_initiator
// Self-checking bench for bus_initiator. A small GPIO-like slave decodes
// bus_a[3:2]: 0 -> gpI1 (input register, read only), 2 -> gpO1 (output
// register, writable). Every committed bus write is logged with its cycle
// number so ordering and back-to-back issue can be checked.
// ---------------------------------------------------------------------------
module tb_bus_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_initiator_if #(.AW(32), .DW(32)) busIf ();

    bus_initiator #(
        .AW(32),
        .DW(32),
        .FIFO_DEPTH(4),
        .RD_WAIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .busIf(busIf)
    );

    logic [31:0] gpI1 = 32'h12345678;
    logic [31:0] gpO1;
    int          cyc = 0;
    logic [31:0] logA [$];
    logic [31:0] logD [$];
    int          logT [$];
    int          checks = 0;
    int          errors = 0;

    // GPIO output register: commits a write on the edge that ends bus_we.
    always @(posedge clk or posedge rst) begin
        if (rst) gpO1 <= 32'h0;
        else if (busIf.bus_we && busIf.bus_a[3:2] == 2'd2) gpO1 <= busIf.bus_wd;
    end

    // Cycle counter and write log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && busIf.bus_we) begin
            logA.push_back(busIf.bus_a);
            logD.push_back(busIf.bus_wd);
            logT.push_back(cyc);
        end
    end

    // Combinational read data from the slave.
    always_comb begin
        case (busIf.bus_a[3:2])
            2'd0:    busIf.bus_rd = gpI1;
            2'd2:    busIf.bus_rd = gpO1;
            default: busIf.bus_rd = 32'hDEADBEEF;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Offer one command and hold it until accepted (bounded).
    task automatic pushCmd(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        logic rdy;
        logic done;
        done = 1'b0;
        @(negedge clk);
        busIf.cmd_valid = 1'b1;
        busIf.cmd_we    = we;
        busIf.cmd_addr  = addr;
        busIf.cmd_wdata = wd;
        for (int t = 0; t < 20 && !done; t++) begin
            rdy = busIf.cmd_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else @(negedge clk);
        end
        #1 busIf.cmd_valid = 1'b0;
        chk("push accepted", {31'b0, done}, 32'd1);
    endtask

    // Wait (bounded) for rsp_valid, sampled on the falling edge.
    task automatic waitRsp(input string name);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (busIf.rsp_valid) seen = 1'b1;
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic chkIdleReset(input string tag);
        chk({tag, " bus_we"},    {31'b0, busIf.bus_we},    32'd0);
        chk({tag, " bus_a"},     busIf.bus_a,              32'd0);
        chk({tag, " bus_wd"},    busIf.bus_wd,             32'd0);
        chk({tag, " rsp_valid"}, {31'b0, busIf.rsp_valid}, 32'd0);
        chk({tag, " rsp_rdata"}, busIf.rsp_rdata,          32'd0);
        chk({tag, " busy"},      {31'b0, busIf.busy},      32'd0);
        chk({tag, " cmd_ready"}, {31'b0, busIf.cmd_ready}, 32'd1);
    endtask

    typedef struct {
        logic        cv;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rr;
        logic        eWe;
        logic [31:0] eA;
        logic        eRv;
        logic [31:0] eRd;
        logic        eCr;
        logic        eBusy;
    } vecT;

    vecT         vecs [13];
    logic [31:0] fA [5];
    logic [31:0] fD [5];

    initial begin
        int k;
        int base;
        logic rdy;

        busIf.cmd_valid = 1'b0;
        busIf.cmd_we    = 1'b0;
        busIf.cmd_addr  = 32'h0;
        busIf.cmd_wdata = 32'h0;
        busIf.rsp_ready = 1'b0;

        // inputs: cv we addr wd rr | expected: bus_we bus_a rsp_valid rsp_rdata cmd_ready busy
        vecs[0]  = '{1'b1, 1'b1, 32'h8, 32'hA5A50001, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h8, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h8, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h8, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 32'h12345678, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h8, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 32'h12345678, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h8, 1'b0, 32'h12345678, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h8, 1'b1, 32'hA5A50001, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h8, 1'b0, 32'hA5A50001, 1'b1, 1'b0};

        fA = '{32'h08, 32'h10, 32'h18, 32'h20, 32'h28};
        fD = '{32'h0000_0F01, 32'h0000_0F02, 32'h0000_0F03, 32'h0000_0F04, 32'h0000_0F05};

        // Reset values while held in reset.
        #12;
        chkIdleReset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table: single write, read with stalled host, read-back of the write.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            busIf.cmd_valid = vecs[i].cv;
            busIf.cmd_we    = vecs[i].we;
            busIf.cmd_addr  = vecs[i].addr;
            busIf.cmd_wdata = vecs[i].wd;
            busIf.rsp_ready = vecs[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d bus_we", i),    {31'b0, busIf.bus_we},    {31'b0, vecs[i].eWe});
            chk($sformatf("v%0d bus_a", i),     busIf.bus_a,              vecs[i].eA);
            chk($sformatf("v%0d rsp_valid", i), {31'b0, busIf.rsp_valid}, {31'b0, vecs[i].eRv});
            chk($sformatf("v%0d rsp_rdata", i), busIf.rsp_rdata,          vecs[i].eRd);
            chk($sformatf("v%0d cmd_ready", i), {31'b0, busIf.cmd_ready}, {31'b0, vecs[i].eCr});
            chk($sformatf("v%0d busy", i),      {31'b0, busIf.busy},      {31'b0, vecs[i].eBusy});
        end
        @(negedge clk);
        busIf.cmd_valid = 1'b0;
        busIf.rsp_ready = 1'b0;
        chk("gpO1 after write", gpO1, 32'hA5A50001);
        chk("write count", logA.size(), 32'd1);

        // Asynchronous reset during a write access drops bus_we at once.
        pushCmd(1'b1, 32'h4, 32'h11111111);
        @(posedge clk);
        #2;
        chk("wr access bus_we", {31'b0, busIf.bus_we}, 32'd1);
        chk("wr access bus_a", busIf.bus_a, 32'h4);
        rst = 1'b1;
        #1;
        chkIdleReset("async rst in write");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("aborted write not committed", logA.size(), 32'd1);

        // Full FIFO: one stalled read, then five writes offered back-to-back.
        base = logA.size();
        pushCmd(1'b0, 32'h0, 32'h0);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (k < 5) begin
                busIf.cmd_valid = 1'b1;
                busIf.cmd_we    = 1'b1;
                busIf.cmd_addr  = fA[k];
                busIf.cmd_wdata = fD[k];
            end else begin
                busIf.cmd_valid = 1'b0;
            end
            rdy = busIf.cmd_ready;
            @(posedge clk);
            if (rdy && busIf.cmd_valid) k++;
        end
        @(negedge clk);
        chk("full accepted", k, 32'd4);
        chk("full cmd_ready", {31'b0, busIf.cmd_ready}, 32'd0);
        chk("full rsp_valid", {31'b0, busIf.rsp_valid}, 32'd1);
        chk("full rsp_rdata", busIf.rsp_rdata, 32'h12345678);
        chk("full no write yet", logA.size() - base, 32'd0);
        busIf.rsp_ready = 1'b1;
        for (int c = 0; c < 10 && k < 5; c++) begin
            @(negedge clk);
            busIf.cmd_valid = 1'b1;
            busIf.cmd_we    = 1'b1;
            busIf.cmd_addr  = fA[k];
            busIf.cmd_wdata = fD[k];
            rdy = busIf.cmd_ready;
            @(posedge clk);
            if (rdy) k++;
        end
        @(negedge clk);
        busIf.cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        busIf.rsp_ready = 1'b0;
        chk("full fifth accepted", k, 32'd5);
        chk("full write count", logA.size() - base, 32'd5);
        if (logA.size() - base == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("full order addr %0d", i), logA[base + i], fA[i]);
                chk($sformatf("full order data %0d", i), logD[base + i], fD[i]);
                if (i > 0) chk($sformatf("full consecutive %0d", i), logT[base + i] - logT[base + i - 1], 32'd1);
            end
        end
        chk("full busy after drain", {31'b0, busIf.busy}, 32'd0);

        // Reset while a response is pending and two writes are queued.
        pushCmd(1'b0, 32'h0, 32'h0);
        pushCmd(1'b1, 32'h8, 32'hCAFE0001);
        pushCmd(1'b1, 32'h8, 32'hCAFE0002);
        waitRsp("resp before reset");
        base = logA.size();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chkIdleReset("async rst in resp");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("queued writes flushed", logA.size() - base, 32'd0);
        chk("gpO1 untouched", gpO1, 32'h0);
        chk("busy after flush", {31'b0, busIf.busy}, 32'd0);
        chk("rsp_valid after flush", {31'b0, busIf.rsp_valid}, 32'd0);

`ifdef BUS_INIT_RDWAIT_EN
        // RD_WAIT=2: address held three cycles, sample taken at the end.
        gpI1 = 32'h1;
        pushCmd(1'b0, 32'h10, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rdwait bus_a c%0d", c), busIf.bus_a, 32'h10);
            chk($sformatf("rdwait rsp_valid c%0d", c), {31'b0, busIf.rsp_valid}, 32'd0);
            if (c == 2) gpI1 = 32'h2;
        end
        @(posedge clk);
        #1;
        chk("rdwait rsp_valid", {31'b0, busIf.rsp_valid}, 32'd1);
        chk("rdwait rsp_rdata", busIf.rsp_rdata, 32'h2);
        busIf.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.rsp_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Memory-mapped bus initiator: the requesting end of the single-cycle peripheral bus that the GPIO and other slaves respond on (address, write-enable, write-data out; read-data in). A host-side engine queues read/write commands into a small FIFO over a valid/ready handshake. The block issues each command as one bus access and returns read data over a second valid/ready handshake. It lets test harnesses and future DMA/sequencer logic drive peripherals without the CPU.

## Interface
Parameters:
- AW, 32, bus address width
- DW, 32, bus data width
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- RD_WAIT, 1, extra address-hold cycles before read sampling; used only under the macro

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  AW  byte address
- cmd_wdata  in  DW  write data; ignored for reads
- rsp_valid  out  1  read data available
- rsp_rdata  out  DW  captured read data
- rsp_ready  in  1  host takes the response
- busy  out  1  FIFO non-empty or FSM not IDLE
- bus_a  out  AW  bus address, registered
- bus_we  out  1  bus write strobe, registered
- bus_wd  out  DW  bus write data, registered
- bus_rd  in  DW  slave read data; combinational from bus_a in the slave

## Operation
- Push: on each edge where cmd_valid && cmd_ready, {we, addr, wdata} enters the FIFO. No push when full, even if a pop happens on the same edge. A push and a pop on the same edge leave the count unchanged.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head, load bus_a/bus_wd, set bus_we = cmd_we, and go to ACCESS.
- ACCESS, write: bus_we=1 for this cycle only; the slave commits at the end of the cycle. On the next edge, if the FIFO is non-empty, pop directly into another ACCESS; otherwise go to IDLE. Writes produce no response.
- ACCESS, read: bus_we=0.
  - Without the macro, or with RD_WAIT=0: capture bus_rd into rsp_rdata at the end of ACCESS and go to RESP.
  - With the macro and RD_WAIT>0: go to WAIT.
- WAIT: hold bus_a for RD_WAIT cycles. Capture bus_rd at the end of the last WAIT cycle, then go to RESP.
- RESP: rsp_valid=1 and rsp_rdata is stable until the edge where rsp_ready=1. On that edge, pop the next command if the FIFO is non-empty (into ACCESS); otherwise go to IDLE.
- bus_we is 0 in every state except write ACCESS. bus_a/bus_wd hold their last values when idle.
- Addresses pass through unmodified; slaves decode their own bits (e.g. a[3:2]).

## Timing
- Reset values: bus_a=0, bus_we=0, bus_wd=0, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=1, FSM=IDLE, FIFO empty.
- Reset is asynchronous. Asserting it mid-operation immediately drops bus_we and rsp_valid, flushes the FIFO, and discards any outstanding read.
- Write latency, from an accepting edge N with an empty FIFO and idle FSM:
  - pop at edge N+1;
  - bus_we high during cycle N+1..N+2;
  - slave updated at edge N+2.
- Read latency from the same start: rsp_valid high after edge N+2. With the macro, add RD_WAIT cycles.
- Throughput:
  - back-to-back writes: one per cycle;
  - reads: one per 2 + RD_WAIT cycles when rsp_ready is held high.
- Command order on the bus equals acceptance order. A later write never overtakes a pending read response.

## Configuration
- Macro BUS_INIT_RDWAIT_EN.
- Defined: WAIT state exists. Reads hold bus_a for 1+RD_WAIT cycles before sampling, for registered-output slaves.
- Undefined: WAIT state and its counter are compiled out, RD_WAIT is ignored, and reads sample at the end of ACCESS.

## Test plan
- Reset: assert rst mid-cycle -> all outputs reach the reset values without waiting for a clock edge; cmd_ready=1 after release.
- Write to a GPIO slave: one write, addr 0x8, data 0xA5A50001 -> bus_we high for exactly one cycle and gpO1 reads 0xA5A50001 afterwards; no rsp_valid.
- Read: gpI1=0x12345678, read addr 0x0, rsp_ready low for 3 cycles -> rsp_valid held with rsp_rdata=0x12345678 throughout; busy drops one cycle after rsp_ready.
- Full FIFO:
  - stimulus: one read with rsp_ready=0, then 5 writes offered back-to-back;
  - cmd_ready falls after 4 accepted, and the 5th is held;
  - raising rsp_ready issues the 4 writes on consecutive cycles in order, then the 5th.
- Macro defined, RD_WAIT=2: change bus_rd from 0x1 to 0x2 in the third address cycle -> bus_a held 3 cycles and rsp_rdata=0x2.
- Reset during RESP with 2 queued writes -> rsp_valid=0 immediately; neither write appears on the bus after release.
